// File: rtl/clock_tick_generator_if.sv
// Control and tick bundle between the clock datapath and its tick generator.
// The generator is the slave: it consumes Run/Clear/Fast and produces the ticks.
interface clock_tick_generator_if;
    logic Run;
    logic Clear;
    logic Fast;
    logic Tick_1Hz;
    logic Tick_2Hz;
    logic Tick_Scan;
    logic Blink;

    modport master (
        output Run, Clear, Fast,
        input  Tick_1Hz, Tick_2Hz, Tick_Scan, Blink
    );

    modport slave (
        input  Run, Clear, Fast,
        output Tick_1Hz, Tick_2Hz, Tick_Scan, Blink
    );
endinterface

// File: rtl/clock_tick_generator.sv
// Sole producer of the single-cycle tick enables for the clock datapath:
// 1 Hz / 2 Hz timekeeping ticks (with a time-set speed-up), a free-running
// display-scan tick, and a 50 % blink level derived from the half-second phase.
module clock_tick_generator #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int SCAN_HZ   = 1000,
    parameter int FAST_MULT = 16
) (
    input  logic                         Clock,
    input  logic                         Reset_n,
    clock_tick_generator_if.slave        bus
);

    localparam int HALF_SLOW = CLK_HZ / 2;
    localparam int HALF_FAST = CLK_HZ / (2 * FAST_MULT);
    localparam int SCAN_DIV  = CLK_HZ / SCAN_HZ;

    // Guard against zero-width counters for degenerate divide ratios.
    localparam int HW = (HALF_SLOW > 1) ? $clog2(HALF_SLOW) : 1;
    localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;

    localparam logic [HW-1:0] HALF_TC_SLOW = HW'(HALF_SLOW - 1);
    localparam logic [HW-1:0] HALF_TC_FAST = HW'(HALF_FAST - 1);
    localparam logic [SW-1:0] SCAN_TC      = SW'(SCAN_DIV - 1);

    logic [HW-1:0] r_half_cnt;
    logic          r_half;
    logic          r_tick_1hz;
    logic          r_tick_2hz;
    logic [SW-1:0] r_scan_cnt;
    logic          r_tick_scan;

    logic [HW-1:0] w_half_tc;
    logic          w_half_wrap;

    // Terminal count follows Fast combinationally; the >= compare makes a
    // mid-count switch to the shorter period wrap on the next counting edge.
    always_comb begin
        w_half_tc   = bus.Fast ? HALF_TC_FAST : HALF_TC_SLOW;
        w_half_wrap = (r_half_cnt >= w_half_tc);
    end

    // Timekeeping divider: Clear beats Run=0, which beats counting.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_half_cnt <= '0;
            r_half     <= 1'b0;
            r_tick_1hz <= 1'b0;
            r_tick_2hz <= 1'b0;
        end else if (bus.Clear) begin
            r_half_cnt <= '0;
            r_half     <= 1'b0;
            r_tick_1hz <= 1'b0;
            r_tick_2hz <= 1'b0;
        end else if (!bus.Run) begin
            r_tick_1hz <= 1'b0;
            r_tick_2hz <= 1'b0;
        end else if (w_half_wrap) begin
            r_half_cnt <= '0;
            r_half     <= ~r_half;
            r_tick_2hz <= 1'b1;
            // The full second ends when the second half-period completes.
            r_tick_1hz <= r_half;
        end else begin
            r_half_cnt <= r_half_cnt + HW'(1);
            r_tick_1hz <= 1'b0;
            r_tick_2hz <= 1'b0;
        end
    end

    // Scan divider free-runs regardless of Run/Clear/Fast.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_scan_cnt  <= '0;
            r_tick_scan <= 1'b0;
        end else if (r_scan_cnt == SCAN_TC) begin
            r_scan_cnt  <= '0;
            r_tick_scan <= 1'b1;
        end else begin
            r_scan_cnt  <= r_scan_cnt + SW'(1);
            r_tick_scan <= 1'b0;
        end
    end

    assign bus.Tick_1Hz  = r_tick_1hz;
    assign bus.Tick_2Hz  = r_tick_2hz;
    assign bus.Tick_Scan = r_tick_scan;
    assign bus.Blink     = r_half;

endmodule
